// File: rtl/reg_read.sv
// reg_read: two-operand register fetch that stalls on GPR/FPR write-pending scoreboards
module reg_read (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_valid,
  input  logic [4:0]       rs1addr,
  input  logic [4:0]       rs2addr,
  input  logic             rs1_fp,
  input  logic             rs2_fp,
  input  logic [4:0]       rdaddr,
  input  logic             rd_en,
  input  logic             rd_fp,
  input  logic [31:0][31:0] gpr,
  input  logic [31:0][31:0] fpr,
  input  logic             wgpr_finish,
  input  logic             wfpr_finish,
  input  logic [4:0]       wb_gaddr,
  input  logic [4:0]       wb_faddr,
  output logic [31:0]      src1,
  output logic [31:0]      src2,
  output logic             read_finish,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [18:0] req_q, req_d;
  logic [31:0] gpend_q, gpend_d, fpend_q, fpend_d, src1_q, src1_d, src2_q, src2_d;
  logic [4:0] r1, r2, rd;
  logic f1, f2, en, fp, accept, haz, cap;
  assign {r1, r2, f1, f2, rd, en, fp} = req_q;
  assign src1 = src1_q;
  assign src2 = src2_q;
  assign read_finish = state_q == DONE;
  assign busy = state_q != IDLE;
  always_comb begin
    accept = state_q == IDLE && read_valid;
    haz = (f1 ? fpend_q[r1] : (r1 != 5'd0 && gpend_q[r1])) || (f2 ? fpend_q[r2] : (r2 != 5'd0 && gpend_q[r2]));
    cap = state_q == WAIT && !haz;
    state_d = accept ? WAIT : cap ? DONE : state_q == DONE ? IDLE : state_q;
    req_d = accept ? {rs1addr, rs2addr, rs1_fp, rs2_fp, rdaddr, rd_en, rd_fp} : req_q;
    src1_d = !cap ? src1_q : f1 ? fpr[r1] : r1 == 5'd0 ? 32'd0 : gpr[r1];
    src2_d = !cap ? src2_q : f2 ? fpr[r2] : r2 == 5'd0 ? 32'd0 : gpr[r2];
    gpend_d = (gpend_q & ~(wgpr_finish ? 32'd1 << wb_gaddr : 32'd0)) | (cap && en && !fp && rd != 5'd0 ? 32'd1 << rd : 32'd0);
    fpend_d = (fpend_q & ~(wfpr_finish ? 32'd1 << wb_faddr : 32'd0)) | (cap && en && fp ? 32'd1 << rd : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= '0;
      gpend_q <= '0;
      fpend_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      gpend_q <= gpend_d;
      fpend_q <= fpend_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
    end
  end
endmodule

// File: tb/tb_reg_read.sv
// tb_reg_read: scoreboard bench for reg_read operand fetch, latency and hazard stalls
module tb_reg_read;
  logic clk = 1'b0;
  logic rst, read_valid, rs1_fp, rs2_fp, rd_en, rd_fp, wgpr_finish, wfpr_finish;
  logic [4:0] rs1addr, rs2addr, rdaddr, wb_gaddr, wb_faddr;
  logic [31:0][31:0] gpr, fpr;
  logic [31:0] src1, src2;
  logic read_finish, busy;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  reg_read dut (
    .clk(clk), .rst(rst), .read_valid(read_valid),
    .rs1addr(rs1addr), .rs2addr(rs2addr), .rs1_fp(rs1_fp), .rs2_fp(rs2_fp),
    .rdaddr(rdaddr), .rd_en(rd_en), .rd_fp(rd_fp), .gpr(gpr), .fpr(fpr),
    .wgpr_finish(wgpr_finish), .wfpr_finish(wfpr_finish),
    .wb_gaddr(wb_gaddr), .wb_faddr(wb_faddr),
    .src1(src1), .src2(src2), .read_finish(read_finish), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (read_finish) begin
      if (exp_q.size() == 0) chk("spurious_finish", 64'd1, 64'd0);
      else chk("operands", {src1, src2}, exp_q.pop_front());
    end
  task automatic issue(input logic [4:0] a1, a2, input logic p1, p2, input logic [4:0] d, input logic e, f, input logic [31:0] e1, e2);
    rs1addr = a1; rs2addr = a2; rs1_fp = p1; rs2_fp = p2;
    rdaddr = d; rd_en = e; rd_fp = f; read_valid = 1'b1;
    exp_q.push_back({e1, e2});
    cyc;
    read_valid = 1'b0;
  endtask
  task automatic rd_plain(input logic [4:0] a1, a2, input logic p1, p2, input logic [4:0] d, input logic e, f, input logic [31:0] e1, e2, input string tag);
    issue(a1, a2, p1, p2, d, e, f, e1, e2);
    chk({tag, "_n1"}, {busy, read_finish}, 2'b10);
    cyc;
    chk({tag, "_n2"}, {busy, read_finish}, 2'b11);
    cyc;
    chk({tag, "_idle"}, {busy, read_finish}, 2'b00);
  endtask
  task automatic release_wb(input logic g, input logic [4:0] a, input string tag);
    if (g) begin wgpr_finish = 1'b1; wb_gaddr = a; end
    else begin wfpr_finish = 1'b1; wb_faddr = a; end
    cyc;
    wgpr_finish = 1'b0;
    wfpr_finish = 1'b0;
    chk({tag, "_m1"}, {busy, read_finish}, 2'b10);
    cyc;
    chk({tag, "_m2"}, {busy, read_finish}, 2'b11);
    cyc;
    chk({tag, "_idle"}, {busy, read_finish}, 2'b00);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 32; i++) begin
      gpr[i] = 32'h1000_0000 + i;
      fpr[i] = 32'hF000_0000 + i;
    end
    gpr[0] = 32'hFFFF_FFFF; gpr[2] = 32'hDEAD_BEEF; gpr[3] = 32'd5; gpr[4] = 32'd7;
    fpr[2] = 32'h3F80_0000;
    rst = 1'b1; read_valid = 1'b1; rs1addr = 5'd3; rs2addr = 5'd4; rs1_fp = 1'b0; rs2_fp = 1'b0;
    rdaddr = 5'd0; rd_en = 1'b0; rd_fp = 1'b0; wgpr_finish = 1'b0; wfpr_finish = 1'b0;
    wb_gaddr = 5'd0; wb_faddr = 5'd0;
    cyc;
    cyc;
    chk("reset_out", {busy, read_finish, src1, src2}, 66'd0);
    rst = 1'b0; read_valid = 1'b0;
    cyc;
    chk("rst_rv_dropped", {busy, read_finish}, 2'b00);
    rd_plain(5'd3, 5'd4, 0, 0, 5'd0, 0, 0, 32'd5, 32'd7, "basic");
    chk("src_hold", {src1, src2}, {32'd5, 32'd7});
    rd_plain(5'd0, 5'd3, 0, 0, 5'd0, 1, 0, 32'd0, 32'd5, "zero_reg");
    rd_plain(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 32'd0, "zero_nohaz");
    rd_plain(5'd1, 5'd4, 0, 0, 5'd5, 1, 0, gpr[1], 32'd7, "set_g5");
    issue(5'd5, 5'd3, 0, 0, 5'd0, 0, 0, gpr[5], 32'd5);
    chk("raw_stall1", {busy, read_finish}, 2'b10);
    read_valid = 1'b1; rs1addr = 5'd4;
    cyc;
    read_valid = 1'b0;
    chk("raw_stall2", {busy, read_finish}, 2'b10);
    cyc;
    chk("raw_stall3", {busy, read_finish}, 2'b10);
    release_wb(1'b1, 5'd5, "raw");
    rd_plain(5'd3, 5'd2, 0, 1, 5'd0, 0, 0, 32'd5, 32'h3F80_0000, "fpr_path");
    rd_plain(5'd1, 5'd1, 0, 0, 5'd7, 1, 1, gpr[1], gpr[1], "set_f7");
    rd_plain(5'd7, 5'd7, 0, 0, 5'd0, 0, 0, gpr[7], gpr[7], "gpr7_free");
    issue(5'd3, 5'd7, 0, 1, 5'd0, 0, 0, 32'd5, fpr[7]);
    chk("fraw_stall1", {busy, read_finish}, 2'b10);
    cyc;
    chk("fraw_stall2", {busy, read_finish}, 2'b10);
    release_wb(1'b0, 5'd7, "fraw");
    rd_plain(5'd8, 5'd8, 0, 0, 5'd8, 1, 0, gpr[8], gpr[8], "self_dep");
    issue(5'd1, 5'd1, 0, 0, 5'd6, 1, 0, gpr[1], gpr[1]);
    wgpr_finish = 1'b1; wb_gaddr = 5'd6;
    cyc;
    wgpr_finish = 1'b0;
    chk("coll_done", {busy, read_finish}, 2'b11);
    cyc;
    issue(5'd1, 5'd6, 0, 0, 5'd0, 0, 0, gpr[1], gpr[6]);
    chk("coll_stall1", {busy, read_finish}, 2'b10);
    cyc;
    chk("coll_stall2", {busy, read_finish}, 2'b10);
    release_wb(1'b1, 5'd6, "coll");
    rd_plain(5'd1, 5'd1, 0, 0, 5'd10, 1, 0, gpr[1], gpr[1], "set_g10");
    issue(5'd10, 5'd1, 0, 0, 5'd12, 1, 0, gpr[10], gpr[1]);
    chk("rstw_stall1", {busy, read_finish}, 2'b10);
    cyc;
    chk("rstw_stall2", {busy, read_finish}, 2'b10);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    exp_q.delete();
    chk("rstw_out", {busy, read_finish, src1, src2}, 66'd0);
    cyc;
    chk("rstw_nopulse", {busy, read_finish}, 2'b00);
    rd_plain(5'd10, 5'd12, 0, 0, 5'd0, 0, 0, gpr[10], gpr[12], "post_rst");
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_read.md
REG_READ -- requirements
Module: reg_read

Interface
REQ-001 clk  in  1  rising-edge clock, sole clock domain.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 read_valid  in  1  one-cycle request pulse to fetch two source operands.
REQ-004 rs1addr, rs2addr  in  5 each  source register indices.
REQ-005 rs1_fp, rs2_fp  in  1 each  source selects FPR file (1) or GPR file (0).
REQ-006 rdaddr  in  5  destination register of the requesting instruction.
REQ-007 rd_en, rd_fp  in  1 each  destination will be written; destination is in the FPR file.
REQ-008 gpr, fpr  in  32x32 each  register file contents (packed [31:0][31:0]).
REQ-009 wgpr_finish, wfpr_finish  in  1 each  write-back completion pulses.
REQ-010 wb_gaddr, wb_faddr  in  5 each  register index completed by the matching finish pulse.
REQ-011 src1, src2  out  32 each  fetched operands, valid while read_finish=1.
REQ-012 read_finish  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high whenever state != IDLE.

Function
REQ-014 The block SHALL use the states IDLE, WAIT and DONE.
REQ-015 IDLE + read_valid: latch rs1addr/rs2addr/rs1_fp/rs2_fp/rdaddr/rd_en/rd_fp; next state WAIT.
REQ-016 read_valid outside IDLE SHALL be ignored, with no latch and no state change.
REQ-017 The block SHALL keep scoreboards gpend[31:0] and fpend[31:0]; bit=1 means a write to that register is outstanding.
REQ-018 A source is hazarded iff its pending bit (registered value, start of cycle) is 1; GPR index 0 is never hazarded.
REQ-019 WAIT with no source hazarded: capture src1/src2 from the selected file; GPR index 0 reads 32'h0 regardless of gpr[0]; next state DONE.
REQ-020 The same WAIT cycle SHALL set gpend[rdaddr] (rd_en & !rd_fp & rdaddr!=0) or fpend[rdaddr] (rd_en & rd_fp).
REQ-021 WAIT with any source hazarded: stay in WAIT; src1/src2 unchanged; no scoreboard set.
REQ-022 DONE: read_finish=1 for exactly that cycle; next state IDLE; src1/src2 hold until the next capture.
REQ-023 Latency: read_valid in cycle N with no hazard gives read_finish in cycle N+2; a hazard adds one cycle per stall cycle.
REQ-024 wgpr_finish SHALL clear gpend[wb_gaddr]; wfpr_finish SHALL clear fpend[wb_faddr]; both may occur in the same cycle, in any state.
REQ-025 A clear is visible to the hazard check one cycle later, with no same-cycle bypass.
REQ-026 Set and clear of the same bit in the same cycle: set wins.
REQ-027 A clear of a non-pending bit SHALL have no effect.
REQ-028 Self-dependency (rs == rd): the hazard check uses the pre-set scoreboard, so it does not self-stall.
REQ-029 busy = (state != IDLE), combinational from the state register.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, gpend=0, fpend=0, src1=0, src2=0, read_finish=0, busy=0.
REQ-031 Reset in WAIT or DONE aborts the request: no read_finish, and no scoreboard bit is set in that cycle.
REQ-032 read_valid asserted together with rst SHALL be discarded.

Verification
REQ-033 No hazard: gpr[3]=5, gpr[4]=7; read rs1=3, rs2=4, rd_en=0 at N -> read_finish at N+2, src1=5, src2=7, busy high in N+1..N+2 only.
REQ-034 Zero register: gpr[0]=32'hFFFF_FFFF; read rs1=0 with rd_en=1, rdaddr=0 -> src1=0, gpend[0] stays 0.
REQ-035 RAW stall: read with rd_en=1, rdaddr=5 completes; second read rs1=5 stalls in WAIT; wgpr_finish with wb_gaddr=5 at cycle M -> capture at M+1, read_finish at M+2.
REQ-036 FPR path: fpr[2]=32'h3F80_0000, read rs2_fp=1, rs2addr=2 -> src2=32'h3F80_0000; gpr[2] has no effect.
REQ-037 Set/clear collision: a WAIT cycle sets gpend[6] while wgpr_finish clears wb_gaddr=6 -> gpend[6]=1 afterwards.
REQ-038 Reset mid-WAIT: assert rst during a stall -> next cycle busy=0, gpend=0, no read_finish pulse.
